// File: rtl/dmem_responder.sv
// dmem_responder: multi-cycle data-memory responder for the MEM pipeline stage.
// It accepts one load or store at a time and holds the pipeline with stall_o
// for LATENCY cycles. Results appear in a single one-cycle DONE slot.
//   clk, rst           : clock; synchronous active-low reset
//   mem_rd_M, mem_wr_M : load / store request (write wins when both are high)
//   mem_mask_M         : funct3 size/sign code
//   alu_o_M            : byte address; wraps modulo 4*DEPTH_WORDS
//   wr_data_M          : right-aligned store data
//   rd_data_M          : extended load result, valid only while rd_valid_M=1
//   rd_valid_M         : one-cycle load-result qualifier
//   stall_o            : pipeline hold (combinational in the accept cycle)
//   misalign_o         : one-cycle access-fault pulse (combinational)
module dmem_responder #(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned LATENCY     = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_rd_M,
    input  logic        mem_wr_M,
    input  logic [2:0]  mem_mask_M,
    input  logic [31:0] alu_o_M,
    input  logic [31:0] wr_data_M,
    output logic [31:0] rd_data_M,
    output logic        rd_valid_M,
    output logic        stall_o,
    output logic        misalign_o
);

    localparam int unsigned IDX_W  = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam int unsigned ADDR_W = IDX_W + 2;
    localparam logic [3:0]  CNT_LOAD = 4'(LATENCY - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_e;

    state_e              state_q, state_d;
    logic [3:0]          cnt_q, cnt_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [2:0]          mask_q, mask_d;
    logic [31:0]         wdata_q, wdata_d;
    logic                wr_q, wr_d;
    logic [31:0]         rd_data_q, rd_data_d;
    logic                rd_valid_q, rd_valid_d;

    logic [31:0]         mem_q [DEPTH_WORDS];

    logic                req_c, code_ok_c, align_ok_c, fault_c, accept_c;
    logic                commit_c;
    logic [IDX_W-1:0]    widx_c;
    logic [3:0]          be_c;
    logic [31:0]         wbus_c;
    logic                unused_addr_c;

    // Upper address bits are deliberately ignored (address wrap).
    assign unused_addr_c = ^alu_o_M[31:ADDR_W];

    // Pick the addressed byte/halfword and sign- or zero-extend it.
    function automatic logic [31:0] load_extend(input logic [31:0] word,
                                                input logic [1:0]  lane,
                                                input logic [2:0]  mask);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] res;
        case (lane)
            2'd0:    b = word[7:0];
            2'd1:    b = word[15:8];
            2'd2:    b = word[23:16];
            default: b = word[31:24];
        endcase
        h = lane[1] ? word[31:16] : word[15:0];
        case (mask[1:0])
            2'b00:   res = mask[2] ? {24'h0, b} : {{24{b[7]}}, b};
            2'b01:   res = mask[2] ? {16'h0, h} : {{16{h[15]}}, h};
            default: res = word;
        endcase
        return res;
    endfunction

    // Request legality: size code per direction, then natural alignment.
    always_comb begin
        req_c = mem_rd_M | mem_wr_M;
        if (mem_wr_M) begin
            code_ok_c = (mem_mask_M == 3'b000) || (mem_mask_M == 3'b001) ||
                        (mem_mask_M == 3'b010);
        end else begin
            code_ok_c = (mem_mask_M == 3'b000) || (mem_mask_M == 3'b001) ||
                        (mem_mask_M == 3'b010) || (mem_mask_M == 3'b100) ||
                        (mem_mask_M == 3'b101);
        end
        case (mem_mask_M[1:0])
            2'b01:   align_ok_c = ~alu_o_M[0];
            2'b10:   align_ok_c = (alu_o_M[1:0] == 2'b00);
            default: align_ok_c = 1'b1;
        endcase
        fault_c  = req_c & ~(code_ok_c & align_ok_c);
        accept_c = rst & (state_q == S_IDLE) & req_c & ~fault_c;
    end

    // Next-state, latched request fields, store lanes and load result.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        addr_d     = addr_q;
        mask_d     = mask_q;
        wdata_d    = wdata_q;
        wr_d       = wr_q;
        rd_data_d  = 32'h0;
        rd_valid_d = 1'b0;
        commit_c   = 1'b0;
        be_c       = 4'h0;
        wbus_c     = 32'h0;

        case (state_q)
            S_IDLE: begin
                if (accept_c) begin
                    addr_d  = alu_o_M[ADDR_W-1:0];
                    mask_d  = mem_mask_M;
                    wdata_d = wr_data_M;
                    wr_d    = mem_wr_M;
                    cnt_d   = CNT_LOAD;
                    state_d = (LATENCY == 1) ? S_DONE : S_BUSY;
                end
            end
            S_BUSY: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_d == 4'd0) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // addr_d/mask_d/wr_d already hold the access fields on the entering
        // edge, which also covers the LATENCY=1 IDLE->DONE shortcut.
        widx_c = addr_d[ADDR_W-1:2];
        if ((state_d == S_DONE) && (state_q != S_DONE)) begin
            if (wr_d) begin
                commit_c = 1'b1;
                case (mask_d[1:0])
                    2'b00: begin
                        be_c   = 4'(4'b0001 << addr_d[1:0]);
                        wbus_c = {4{wdata_d[7:0]}};
                    end
                    2'b01: begin
                        be_c   = addr_d[1] ? 4'b1100 : 4'b0011;
                        wbus_c = {2{wdata_d[15:0]}};
                    end
                    default: begin
                        be_c   = 4'b1111;
                        wbus_c = wdata_d;
                    end
                endcase
            end else begin
                rd_valid_d = 1'b1;
                rd_data_d  = load_extend(mem_q[widx_c], addr_d[1:0], mask_d);
            end
        end
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            cnt_q      <= 4'd0;
            addr_q     <= '0;
            mask_q     <= 3'd0;
            wdata_q    <= 32'h0;
            wr_q       <= 1'b0;
            rd_data_q  <= 32'h0;
            rd_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            addr_q     <= addr_d;
            mask_q     <= mask_d;
            wdata_q    <= wdata_d;
            wr_q       <= wr_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
        end
    end

    // Data array: not cleared by reset; a reset edge drops a pending commit.
    always_ff @(posedge clk) begin
        if (rst && commit_c) begin
            for (int l = 0; l < 4; l++) begin
                if (be_c[l]) begin
                    mem_q[widx_c][8*l +: 8] <= wbus_c[8*l +: 8];
                end
            end
        end
    end

    assign stall_o    = rst & (accept_c | (state_q == S_BUSY));
    assign misalign_o = rst & (state_q == S_IDLE) & fault_c;
    assign rd_data_M  = rd_data_q;
    assign rd_valid_M = rd_valid_q;

endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: directed, table-driven checks of dmem_responder
// (DEPTH_WORDS=1024, LATENCY=2), plus hand sequences for reset and DONE.
module tb_dmem_responder;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_rd_M, mem_wr_M;
    logic [2:0]  mem_mask_M;
    logic [31:0] alu_o_M, wr_data_M;
    logic [31:0] rd_data_M;
    logic        rd_valid_M, stall_o, misalign_o;

    int unsigned n_vec = 0;
    int unsigned n_err = 0;

    always #5 clk = ~clk;

    dmem_responder #(.DEPTH_WORDS(1024), .LATENCY(2)) dut (
        .clk        (clk),
        .rst        (rst),
        .mem_rd_M   (mem_rd_M),
        .mem_wr_M   (mem_wr_M),
        .mem_mask_M (mem_mask_M),
        .alu_o_M    (alu_o_M),
        .wr_data_M  (wr_data_M),
        .rd_data_M  (rd_data_M),
        .rd_valid_M (rd_valid_M),
        .stall_o    (stall_o),
        .misalign_o (misalign_o)
    );

    typedef struct {
        logic        rd;
        logic        wr;
        logic [2:0]  mask;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        fault;
        logic [31:0] exp;
    } vec_t;

    localparam int NV = 25;
    vec_t vecs [NV];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic rd, input logic wr, input logic [2:0] m,
                         input logic [31:0] a, input logic [31:0] d);
        mem_rd_M   = rd;
        mem_wr_M   = wr;
        mem_mask_M = m;
        alu_o_M    = a;
        wr_data_M  = d;
    endtask

    task automatic check_quiet(input string tag);
        check({tag, " stall"},    32'(stall_o),    32'h0);
        check({tag, " valid"},    32'(rd_valid_M), 32'h0);
        check({tag, " misalign"}, 32'(misalign_o), 32'h0);
        check({tag, " rdata"},    rd_data_M,       32'h0);
    endtask

    // One access: accept cycle, one BUSY cycle, DONE, then back in IDLE.
    task automatic run_vec(input vec_t v, input int idx);
        string t;
        logic  is_load;
        t = $sformatf("v%0d", idx);
        is_load = v.rd & ~v.wr;
        step();
        drive(v.rd, v.wr, v.mask, v.addr, v.wdata);
        @(negedge clk);
        if (v.fault) begin
            check({t, " fault misalign"}, 32'(misalign_o), 32'h1);
            check({t, " fault stall"},    32'(stall_o),    32'h0);
            step();
            drive(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
            @(negedge clk);
            check_quiet({t, " after fault"});
        end else begin
            check({t, " T stall"},    32'(stall_o),    32'h1);
            check({t, " T misalign"}, 32'(misalign_o), 32'h0);
            step();
            // Junk on the data inputs while busy must not disturb the access.
            drive(1'b0, 1'b0, 3'b111, 32'hFFFF_FFFF, 32'h5A5A_5A5A);
            @(negedge clk);
            check({t, " busy stall"}, 32'(stall_o),    32'h1);
            check({t, " busy valid"}, 32'(rd_valid_M), 32'h0);
            step();
            drive(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
            @(negedge clk);
            check({t, " done stall"}, 32'(stall_o),    32'h0);
            check({t, " done valid"}, 32'(rd_valid_M), 32'(is_load));
            check({t, " done rdata"}, rd_data_M,       is_load ? v.exp : 32'h0);
            step();
            @(negedge clk);
            check_quiet({t, " idle"});
        end
    endtask

    initial begin
        //             rd    wr    mask    addr           wdata          fault exp
        vecs[0]  = '{1'b0, 1'b1, 3'b010, 32'h0000_0010, 32'hDEAD_BEEF, 1'b0, 32'h0};
        vecs[1]  = '{1'b1, 1'b0, 3'b010, 32'h0000_0010, 32'h0,         1'b0, 32'hDEAD_BEEF};
        vecs[2]  = '{1'b1, 1'b0, 3'b000, 32'h0000_0013, 32'h0,         1'b0, 32'hFFFF_FFDE};
        vecs[3]  = '{1'b1, 1'b0, 3'b100, 32'h0000_0013, 32'h0,         1'b0, 32'h0000_00DE};
        vecs[4]  = '{1'b1, 1'b0, 3'b001, 32'h0000_0010, 32'h0,         1'b0, 32'hFFFF_BEEF};
        vecs[5]  = '{1'b1, 1'b0, 3'b101, 32'h0000_0012, 32'h0,         1'b0, 32'h0000_DEAD};
        vecs[6]  = '{1'b0, 1'b1, 3'b000, 32'h0000_0011, 32'hFFFF_FF55, 1'b0, 32'h0};
        vecs[7]  = '{1'b1, 1'b0, 3'b010, 32'h0000_0010, 32'h0,         1'b0, 32'hDEAD_55EF};
        vecs[8]  = '{1'b1, 1'b0, 3'b010, 32'h0000_0012, 32'h0,         1'b1, 32'h0};
        vecs[9]  = '{1'b0, 1'b1, 3'b001, 32'h0000_0011, 32'h0000_FFFF, 1'b1, 32'h0};
        vecs[10] = '{1'b1, 1'b0, 3'b010, 32'h0000_0010, 32'h0,         1'b0, 32'hDEAD_55EF};
        vecs[11] = '{1'b1, 1'b0, 3'b011, 32'h0000_0010, 32'h0,         1'b1, 32'h0};
        vecs[12] = '{1'b1, 1'b0, 3'b110, 32'h0000_0010, 32'h0,         1'b1, 32'h0};
        vecs[13] = '{1'b0, 1'b1, 3'b100, 32'h0000_0010, 32'h0,         1'b1, 32'h0};
        vecs[14] = '{1'b1, 1'b0, 3'b001, 32'h0000_0011, 32'h0,         1'b1, 32'h0};
        vecs[15] = '{1'b0, 1'b1, 3'b010, 32'h0000_1000, 32'h1234_5678, 1'b0, 32'h0};
        vecs[16] = '{1'b1, 1'b0, 3'b010, 32'h0000_0000, 32'h0,         1'b0, 32'h1234_5678};
        vecs[17] = '{1'b0, 1'b1, 3'b010, 32'h0000_0014, 32'h1122_3344, 1'b0, 32'h0};
        vecs[18] = '{1'b0, 1'b1, 3'b001, 32'h0000_0016, 32'h0000_CAFE, 1'b0, 32'h0};
        vecs[19] = '{1'b1, 1'b0, 3'b010, 32'h0000_0014, 32'h0,         1'b0, 32'hCAFE_3344};
        vecs[20] = '{1'b1, 1'b0, 3'b000, 32'h0000_0015, 32'h0,         1'b0, 32'h0000_0033};
        vecs[21] = '{1'b1, 1'b0, 3'b001, 32'h0000_0016, 32'h0,         1'b0, 32'hFFFF_CAFE};
        vecs[22] = '{1'b1, 1'b1, 3'b010, 32'h0000_0018, 32'h0BAD_F00D, 1'b0, 32'h0};
        vecs[23] = '{1'b1, 1'b0, 3'b010, 32'h0000_0018, 32'h0,         1'b0, 32'h0BAD_F00D};
        vecs[24] = '{1'b1, 1'b0, 3'b010, 32'h8000_0010, 32'h0,         1'b0, 32'hDEAD_55EF};

        // Reset with a request pending: everything must stay quiet.
        rst = 1'b0;
        drive(1'b1, 1'b0, 3'b010, 32'h10, 32'h0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_quiet($sformatf("reset%0d", i));
        end
        step();
        rst = 1'b1;
        drive(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
        @(negedge clk);
        check_quiet("post reset");

        for (int i = 0; i < NV; i++) begin
            run_vec(vecs[i], i);
        end

        // Request held high through DONE: DONE must not accept, IDLE re-accepts.
        step();
        drive(1'b1, 1'b0, 3'b010, 32'h10, 32'h0);
        @(negedge clk);
        check("hold T stall", 32'(stall_o), 32'h1);
        step();
        @(negedge clk);
        check("hold busy stall", 32'(stall_o), 32'h1);
        step();
        @(negedge clk);
        check("hold done stall", 32'(stall_o), 32'h0);
        check("hold done valid", 32'(rd_valid_M), 32'h1);
        check("hold done rdata", rd_data_M, 32'hDEAD_55EF);
        step();
        @(negedge clk);
        check("hold reaccept stall", 32'(stall_o), 32'h1);
        check("hold reaccept valid", 32'(rd_valid_M), 32'h0);
        step();
        drive(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
        step();
        step();
        @(negedge clk);
        check_quiet("hold drained");

        // Known prior contents at 0x20, then a store aborted by reset mid-BUSY.
        run_vec('{1'b0, 1'b1, 3'b010, 32'h20, 32'h0102_0304, 1'b0, 32'h0}, 100);
        step();
        drive(1'b0, 1'b1, 3'b010, 32'h20, 32'hAAAA_AAAA);
        @(negedge clk);
        check("abort T stall", 32'(stall_o), 32'h1);
        step();
        drive(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
        rst = 1'b0;
        @(negedge clk);
        check("abort rst stall", 32'(stall_o), 32'h0);
        step();
        rst = 1'b1;
        @(negedge clk);
        check_quiet("abort next");
        step();
        @(negedge clk);
        check_quiet("abort next2");
        run_vec('{1'b1, 1'b0, 3'b010, 32'h20, 32'h0, 1'b0, 32'h0102_0304}, 101);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
